// File: rtl/rate_limiter_mc_if.sv
// Target-write and beat-output streams of the multi-channel rate limiter.
interface rate_limiter_mc_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 6
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [CH_W-1:0]   in_chan;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_chan;
  logic [DATA_W-1:0] out_data;

  // Producer of target writes and consumer of beats.
  modport master (
    output in_valid, in_chan, in_data, out_ready,
    input  in_ready, out_valid, out_chan, out_data
  );

  // The rate limiter itself.
  modport slave (
    input  in_valid, in_chan, in_data, out_ready,
    output in_ready, out_valid, out_chan, out_data
  );
endinterface

// File: rtl/rate_limiter_mc.sv
// N-channel slew-rate limiter with a round-robin output scan.
// Optional feature: define RATE_LIM_BYPASS_EN to add a bypass input that
// makes a serviced channel jump straight to its target.
module rate_limiter_mc #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 6,
  parameter int unsigned STEP_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  rate_limiter_mc_if.slave    bus,
  input  logic [STEP_W-1:0]   up_step,
  input  logic [STEP_W-1:0]   down_step,
`ifdef RATE_LIM_BYPASS_EN
  input  logic                bypass,
`endif
  output logic [N_CH-1:0]     settled
);
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned EXT_W = DATA_W + 1;

  logic [DATA_W-1:0] target [N_CH];
  logic [DATA_W-1:0] value  [N_CH];
  logic [CH_W-1:0]   ptr;

  logic              service;
  logic              write_en;
  logic              bypass_on;
  logic [DATA_W-1:0] cur_v;
  logic [DATA_W-1:0] cur_t;
  logic [DATA_W-1:0] next_v;
  logic [EXT_W-1:0]  gap_up;
  logic [EXT_W-1:0]  gap_dn;
  logic [EXT_W-1:0]  up_ext;
  logic [EXT_W-1:0]  dn_ext;

`ifdef RATE_LIM_BYPASS_EN
  assign bypass_on = bypass;
`else
  assign bypass_on = 1'b0;
`endif

  // Writes are accepted whenever the block is out of reset.
  assign bus.in_ready = ~reset;
  assign write_en     = bus.in_valid & bus.in_ready;
  // A new beat is produced when the output register is empty or draining.
  assign service      = ~bus.out_valid | bus.out_ready;

  // Slew step for the channel under the scan pointer; steps never overshoot the target.
  always_comb begin
    cur_v  = value[ptr];
    cur_t  = target[ptr];
    up_ext = EXT_W'(up_step);
    dn_ext = EXT_W'(down_step);
    gap_up = EXT_W'(cur_t) - EXT_W'(cur_v);
    gap_dn = EXT_W'(cur_v) - EXT_W'(cur_t);
    next_v = cur_v;
    if (bypass_on) begin
      next_v = cur_t;
    end else if (cur_v < cur_t) begin
      next_v = (gap_up > up_ext) ? DATA_W'(EXT_W'(cur_v) + up_ext) : cur_t;
    end else if (cur_v > cur_t) begin
      next_v = (gap_dn > dn_ext) ? DATA_W'(EXT_W'(cur_v) - dn_ext) : cur_t;
    end
  end

  // Target registers; out-of-range channel writes are accepted and dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) target[c] <= '0;
    end else if (write_en && (32'(bus.in_chan) < N_CH)) begin
      target[bus.in_chan] <= bus.in_data;
    end
  end

  // Value update, scan pointer and output beat register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) value[c] <= '0;
      ptr          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_chan  <= '0;
      bus.out_data  <= '0;
    end else if (service) begin
      value[ptr]    <= next_v;
      bus.out_data  <= next_v;
      bus.out_chan  <= ptr;
      bus.out_valid <= 1'b1;
      ptr           <= (ptr == CH_W'(N_CH - 1)) ? '0 : ptr + CH_W'(1);
    end
  end

  // Per-channel settled flags from the registered state (one cycle behind).
  always_ff @(posedge clk) begin
    if (reset) begin
      settled <= '1;
    end else begin
      for (int c = 0; c < N_CH; c++) settled[c] <= (value[c] == target[c]);
    end
  end
endmodule

// File: tb/tb_rate_limiter_mc.sv
// Self-checking bench for rate_limiter_mc: directed scenarios plus random traffic
// against a per-channel behavioural model. Honors RATE_LIM_BYPASS_EN.
module tb_rate_limiter_mc;
  localparam int unsigned N_CH   = 4;
  localparam int unsigned DATA_W = 6;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned CH_W   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [STEP_W-1:0] up_step;
  logic [STEP_W-1:0] down_step;
  logic [N_CH-1:0]   settled;
`ifdef RATE_LIM_BYPASS_EN
  logic              bypass;
`endif

  rate_limiter_mc_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

  rate_limiter_mc #(.N_CH(N_CH), .DATA_W(DATA_W), .STEP_W(STEP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .up_step   (up_step),
    .down_step (down_step),
`ifdef RATE_LIM_BYPASS_EN
    .bypass    (bypass),
`endif
    .settled   (settled)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: per-channel target/value, scan position, current beat.
  int          m_tgt [N_CH];
  int          m_val [N_CH];
  int          m_ptr;
  bit          m_valid;
  int          m_chan;
  int          m_data;
  bit [N_CH-1:0] m_settled;
  bit          model_ok = 0;

  int bq_chan[$];
  int bq_data[$];

  function automatic int slew(input int v, input int t, input int up, input int dn, input bit byp);
    if (byp) return t;
    if (v < t) return (v + up < t) ? v + up : t;
    if (v > t) return (v - dn > t) ? v - dn : t;
    return v;
  endfunction

  // Compare DUT to model mid-cycle, then advance the model across the coming edge.
  always @(negedge clk) begin
    bit [N_CH-1:0] new_set;
    bit byp;
    if (model_ok) begin
      check("in_ready", int'(bus.in_ready), int'(!reset));
      check("out_valid", int'(bus.out_valid), int'(m_valid));
      if (m_valid) begin
        check("out_chan", int'(bus.out_chan), m_chan);
        check("out_data", int'(bus.out_data), m_data);
      end
      check("settled", int'(settled), int'(m_settled));
      if (!reset && bus.out_valid && bus.out_ready) begin
        bq_chan.push_back(int'(bus.out_chan));
        bq_data.push_back(int'(bus.out_data));
      end
    end
`ifdef RATE_LIM_BYPASS_EN
    byp = bypass;
`else
    byp = 1'b0;
`endif
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        m_tgt[c] = 0;
        m_val[c] = 0;
      end
      m_ptr = 0; m_valid = 0; m_chan = 0; m_data = 0; m_settled = '1;
    end else begin
      for (int c = 0; c < N_CH; c++) new_set[c] = (m_val[c] == m_tgt[c]);
      if (!m_valid || bus.out_ready) begin
        m_data = slew(m_val[m_ptr], m_tgt[m_ptr], int'(up_step), int'(down_step), byp);
        m_val[m_ptr] = m_data;
        m_chan  = m_ptr;
        m_valid = 1;
        m_ptr   = (m_ptr + 1) % N_CH;
      end
      if (bus.in_valid && int'(bus.in_chan) < N_CH) m_tgt[int'(bus.in_chan)] = int'(bus.in_data);
      m_settled = new_set;
    end
    model_ok = 1;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_beats();
    bq_chan.delete();
    bq_data.delete();
  endtask

  task automatic write_tgt(input int ch, input int val);
    bus.in_valid = 1'b1;
    bus.in_chan  = CH_W'(ch);
    bus.in_data  = DATA_W'(val);
    cycle();
    bus.in_valid = 1'b0;
  endtask

  int exp_q[$];

  // Compare the next accepted beats of one channel, skipping leading stale values.
  task automatic expect_seq(input string name, input int ch, input int skip);
    int got = 0;
    int cyc = 0;
    bit skipping = 1;
    int c, d;
    while (got < exp_q.size() && cyc < 400) begin
      cycle();
      cyc++;
      while (bq_chan.size() > 0) begin
        c = bq_chan.pop_front();
        d = bq_data.pop_front();
        if (c == ch && got < exp_q.size()) begin
          if (!(skipping && d == skip)) begin
            skipping = 0;
            check(name, d, exp_q[got]);
            got++;
          end
        end
      end
    end
    if (got < exp_q.size()) check({name, "_timeout"}, got, exp_q.size());
  endtask

  initial begin
    int c0, d0, cyc;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_chan = '0; bus.in_data = '0; bus.out_ready = 1'b1;
    up_step = 3'd3; down_step = 3'd7;
`ifdef RATE_LIM_BYPASS_EN
    bypass = 1'b0;
`endif
    repeat (3) cycle();
    check("rst_settled", int'(settled), 15);
    check("rst_out_valid", int'(bus.out_valid), 0);
    reset = 1'b0;

    // Rise on ch2 with step 3.
    clear_beats();
    write_tgt(2, 20);
    exp_q = {3, 6, 9, 12, 15, 18, 20, 20};
    expect_seq("ramp_up_ch2", 2, 0);
    check("settled_ch2", int'(settled[2]), 1);

    // Bring ch0 to 40, then fall to 5 with step 7.
    up_step = 3'd7;
    write_tgt(0, 40);
    repeat (40) cycle();
    clear_beats();
    write_tgt(0, 5);
    exp_q = {33, 26, 19, 12, 5, 5};
    expect_seq("ramp_dn_ch0", 0, 40);

    // Full-scale ramp on ch1 without wrap.
    clear_beats();
    write_tgt(1, 63);
    exp_q = {7, 14, 21, 28, 35, 42, 49, 56, 63, 63};
    expect_seq("full_up_ch1", 1, 0);
    clear_beats();
    write_tgt(1, 0);
    exp_q = {56, 49, 42, 35, 28, 21, 14, 7, 0, 0};
    expect_seq("full_dn_ch1", 1, 63);

    // Stall mid-ramp; the model tracks frozen outputs and the resume order.
    up_step = 3'd1;
    write_tgt(3, 40);
    repeat (6) cycle();
    bus.out_ready = 1'b0;
    repeat (5) cycle();
    bus.out_ready = 1'b1;
    repeat (8) cycle();

    // Reset mid-ramp.
    up_step = 3'd2;
    write_tgt(1, 50);
    repeat (15) cycle();
    reset = 1'b1;
    cycle();
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_settled", int'(settled), 15);
    reset = 1'b0;
    clear_beats();
    cyc = 0;
    while (bq_chan.size() == 0 && cyc < 20) begin
      cycle();
      cyc++;
    end
    if (bq_chan.size() == 0) check("first_beat_timeout", 0, 1);
    else begin
      c0 = bq_chan.pop_front();
      d0 = bq_data.pop_front();
      check("first_beat_chan", c0, 0);
      check("first_beat_data", d0, 0);
    end

`ifdef RATE_LIM_BYPASS_EN
    // Bypass jump on ch2.
    bypass = 1'b1;
    clear_beats();
    write_tgt(2, 50);
    exp_q = {50};
    expect_seq("bypass_ch2", 2, 0);
    bypass = 1'b0;
`endif

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 2) == 0);
      bus.in_chan   = CH_W'($urandom_range(0, N_CH - 1));
      bus.in_data   = DATA_W'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      up_step       = STEP_W'($urandom);
      down_step     = STEP_W'($urandom);
      reset         = ($urandom_range(0, 299) == 0);
`ifdef RATE_LIM_BYPASS_EN
      bypass        = ($urandom_range(0, 9) == 0);
`endif
      cycle();
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
